// File: rtl/booth_ctrl.sv
// booth_ctrl: radix-4 Booth multiply sequencer driving an external step unit.
// Ports: clk, rst (sync, active-high); start/a/b in; busy/done/product out;
// step_mult_1/step_mult_2/step_mult_pre/step_en to the step unit,
// step_rdy/step_mult_next from it; err = step timeout (BOOTH_CTRL_TIMEOUT_EN).
module booth_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic        busy,
  output logic        done,
  output logic [23:0] product,
  output logic [2:0]  step_mult_1,
  output logic [11:0] step_mult_2,
  output logic [23:0] step_mult_pre,
  output logic        step_en,
  input  logic        step_rdy,
  input  logic [23:0] step_mult_next,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t      state, state_d;
  logic [11:0] a_q, b_q;
  logic [23:0] acc, prod_q;
  logic [2:0]  idx;
  logic [12:0] a_ext;
  logic [3:0]  sel;
  logic        tmo;

  // a[-1] = 0 sits at a_ext[0], so digit idx reads a_ext[2*idx +: 3]
  assign a_ext = {a_q, 1'b0};
  assign sel   = {idx, 1'b0};

`ifdef BOOTH_CTRL_TIMEOUT_EN
  logic [3:0] cnt;
  logic       err_q;
  assign tmo = (state == WAIT) && !step_rdy && (cnt == 4'd7);
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d       = state;
    busy          = 1'b0;
    done          = 1'b0;
    step_en       = 1'b0;
    step_mult_1   = 3'd0;
    step_mult_2   = 12'd0;
    step_mult_pre = 24'd0;
    unique case (state)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        busy          = 1'b1;
        step_en       = 1'b1;
        step_mult_1   = a_ext[sel +: 3];
        step_mult_2   = b_q;
        step_mult_pre = {acc[21:0], 2'b00};
        state_d       = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (step_rdy)
          state_d = (idx == 3'd0) ? DONE : ISSUE;
        else if (tmo)
          state_d = IDLE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // product follows acc during the done pulse, then holds in prod_q
  assign product = (state == DONE) ? acc : prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      prod_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            idx <= 3'd5;
          end
        end
        WAIT: begin
          if (step_rdy) begin
            acc <= step_mult_next;
            if (idx != 3'd0) idx <= idx - 3'd1;
          end
        end
        DONE:    prod_q <= acc;
        default: ;
      endcase
    end
  end

`ifdef BOOTH_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) err_q <= 1'b0;
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT && !step_rdy) cnt <= cnt + 4'd1;
      if (tmo) err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: random + directed multiplies against a*b, with a
// step-unit model, a done scoreboard and per-cycle step-port monitor.
module tb_booth_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] a, b;
  logic        busy, done, err, step_en, step_rdy;
  logic [23:0] product, step_mult_pre, step_mult_next;
  logic [2:0]  step_mult_1;
  logic [11:0] step_mult_2;

  booth_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .step_mult_1(step_mult_1), .step_mult_2(step_mult_2),
    .step_mult_pre(step_mult_pre), .step_en(step_en),
    .step_rdy(step_rdy), .step_mult_next(step_mult_next),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [23:0] p;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0;
  int          c0 = -100;
  logic [11:0] cur_a, cur_b;
  bit          spur = 0, hold = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // step unit: result one cycle after step_en = pre + digit*mult_2
  initial begin
    logic        en_s;
    logic [2:0]  t_s;
    logic [23:0] pre_s;
    logic [11:0] m2_s;
    int          d, p, bb, nx;
    step_rdy = 0;
    step_mult_next = 0;
    forever begin
      @(negedge clk);
      en_s = step_en;
      t_s = step_mult_1;
      pre_s = step_mult_pre;
      m2_s = step_mult_2;
      @(posedge clk);
      #1;
      if (hold) begin
        step_rdy = 0;
        step_mult_next = 0;
      end else if (en_s) begin
        d = int'(t_s[1]) + int'(t_s[0]) - 2 * int'(t_s[2]);
        p = $signed(pre_s);
        bb = $signed(m2_s);
        nx = p + d * bb;
        step_rdy = 1;
        step_mult_next = nx[23:0];
      end else if (spur) begin
        step_rdy = 1'($urandom_range(0, 1));
        step_mult_next = 24'($urandom);
      end else begin
        step_rdy = 0;
        step_mult_next = 0;
      end
    end
  end

  // monitor: done scoreboard and step-port checks
  initial begin
    exp_t        e;
    logic [12:0] ae;
    logic [12:0] et;
    int          r, i;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("product", 32'(product), 32'(e.p));
          chk("done_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (step_en) begin
        r = cyc - c0;
        chk("step_en_cycle", 32'(r >= 1 && r <= 11 && r % 2 == 1), 32'd1);
        chk("step_mult_2", 32'(step_mult_2), 32'(cur_b));
        if (r >= 1 && r <= 11) begin
          i = 5 - (r - 1) / 2;
          ae = {cur_a, 1'b0};
          et = (ae >> (2 * i)) & 13'h7;
          chk("step_mult_1", 32'(step_mult_1), 32'(et));
        end
      end else begin
        chk("step_idle_zero",
            32'(|{step_mult_1, step_mult_2, step_mult_pre}), 32'd0);
      end
    end
  end

  task automatic launch(input logic [11:0] va, input logic [11:0] vb);
    @(posedge clk);
    #1;
    start = 1;
    a = va;
    b = vb;
    c0 = cyc;
    cur_a = va;
    cur_b = vb;
  endtask

  task automatic run(input logic [11:0] va, input logic [11:0] vb,
                     input bit noisy);
    exp_t e;
    int   pa, pb, pr;
    launch(va, vb);
    pa = $signed(va);
    pb = $signed(vb);
    pr = pa * pb;
    e.c = c0 + 13;
    e.p = pr[23:0];
    q.push_back(e);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      start = noisy && (k == 4 || k == 13);
      a = 12'($urandom);
      b = 12'($urandom);
      if (k == 1) chk("err_clear", 32'(err), 32'd0);
      if (k == 1 || k == 12) chk("busy_run", 32'(busy), 32'd1);
      if (k == 15) chk("busy_idle", 32'(busy), 32'd0);
    end
    start = 0;
  endtask

  function automatic logic [11:0] rnd_b();
    logic [11:0] v;
    v = 12'($urandom);
    if (v == 12'h800) v = 12'h7FF;
    return v;
  endfunction

  initial begin
    rst = 1;
    start = 0;
    a = 0;
    b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_step_en", 32'(step_en), 32'd0);

    run(12'd3, 12'd5, 0);
    run(12'hFFF, 12'hFFF, 0);
    run(12'h800, 12'h7FF, 0);
    run(12'h7FF, 12'h7FF, 0);
    run(12'h800, 12'h001, 0);
    run(12'd0, 12'h7FF, 0);
    run(12'd3, 12'd5, 1);

    spur = 1;
    run(12'h5A5, 12'hC3C, 0);
    for (int n = 0; n < 6; n++) run(12'($urandom), rnd_b(), 1);
    spur = 0;

    for (int n = 0; n < 20; n++) run(12'($urandom), rnd_b(), n % 3 == 0);

    launch(12'h123, 12'h456);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      start = 0;
      rst = (k == 6);
      if (k == 7) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_step_en", 32'(step_en), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
      end
    end
    c0 = -100;
    run(12'hABC, 12'h321, 0);

`ifdef BOOTH_CTRL_TIMEOUT_EN
    hold = 1;
    launch(12'd7, 12'd9);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      start = 0;
      if (k == 9) chk("tmo_wait_err", 32'(err), 32'd0);
      if (k == 10) begin
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
      end
      if (k == 12) chk("tmo_err_sticky", 32'(err), 32'd1);
    end
    hold = 0;
    c0 = -100;
    run(12'd7, 12'd9, 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("pending_done", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 SHALL have ports clk in 1 (system clock, rising edge) and rst in 1 (synchronous, active-high reset); one clock, reset synchronous active-high.
REQ-002 SHALL have start in 1: request a multiply; sampled only in IDLE.
REQ-003 SHALL have a in 12: signed multiplier, Booth-recoded.
REQ-004 SHALL have b in 12: signed multiplicand, passed to the step unit.
REQ-005 SHALL have busy out 1: high from the cycle after an accepted start until done.
REQ-006 SHALL have done out 1: one-cycle pulse, product valid.
REQ-007 SHALL have product out 24: signed a*b, held from done until the next accepted start.
REQ-008 SHALL have step_mult_1 out 3: Booth triplet to the step unit.
REQ-009 SHALL have step_mult_2 out 12: multiplicand to the step unit, equal to the latched b.
REQ-010 SHALL have step_mult_pre out 24: accumulator input to the step unit.
REQ-011 SHALL have step_en out 1: step request.
REQ-012 SHALL have step_rdy in 1: step result valid; it arrives one cycle after step_en.
REQ-013 SHALL have step_mult_next in 24: step result, equal to mult_pre + digit*b.
REQ-014 SHALL have err out 1: step timeout flag; exists only under REQ-032.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-016 IDLE with start=1: SHALL latch a and b, clear acc to 0, set idx=5 and go to ISSUE; busy=1 from the next cycle.
REQ-017 ISSUE: SHALL drive step_en=1 for exactly one cycle, then go to WAIT.
REQ-018 In ISSUE, step_mult_1 SHALL be {a[2*idx+1], a[2*idx], a[2*idx-1]}, with a[-1]=0.
REQ-019 In ISSUE, step_mult_pre SHALL be acc<<2, truncated to 24 bits (MSB-first Horner evaluation).
REQ-020 WAIT: step_en SHALL be 0; on step_rdy=1 the block SHALL set acc <= step_mult_next.
REQ-021 WAIT, on capture: if idx=0 go to DONE, else decrement idx and go to ISSUE.
REQ-022 DONE: SHALL set product <= acc, pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-023 Latency: start sampled at cycle 0; done=1 at cycle 13 (6 steps x 2 cycles + 1).
REQ-024 start while busy or in DONE: SHALL be ignored; no queuing.
REQ-025 Outside ISSUE, step_* outputs SHALL be 0.
REQ-026 step_rdy seen outside WAIT: SHALL be ignored.
REQ-027 b = -2048 (12'h800): not supported; product is unspecified. All other a and b values SHALL give an exact 24-bit signed product.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE.
REQ-029 Reset values: busy=0, done=0, err=0, product=0, step_en=0, acc=0, idx=0.
REQ-030 rst mid-operation SHALL abort the multiply with no done pulse; step_en=0 from the next cycle.
REQ-031 rst SHALL take priority over start and step_rdy in the same cycle.

Configuration
REQ-032 Macro BOOTH_CTRL_TIMEOUT_EN, when defined:
- an internal 4-bit counter SHALL count WAIT cycles;
- if step_rdy has not arrived after 8 WAIT cycles, the block SHALL set err=1 (sticky until the next accepted start or rst), go to IDLE with busy=0 and give no done pulse.
REQ-033 Macro BOOTH_CTRL_TIMEOUT_EN, when not defined:
- no counter SHALL be built;
- err SHALL be tied to 0;
- WAIT SHALL hold indefinitely.

Verification
REQ-034 Scenario: a=3, b=5, start pulse -> step_en pulses at cycles 1,3,5,7,9,11; done at cycle 13 with product=24'h00000F.
REQ-035 Scenario: a=-1 (12'hFFF), b=-1 -> product=24'h000001; a=-2048, b=2047 -> product=24'hC00800; a=2047, b=2047 -> product=24'h3FF001.
REQ-036 Scenario: start re-asserted at cycles 4 and 13 during an a=3, b=5 run with a different a -> the ignored starts have no effect; single done at cycle 13 with 24'h00000F.
REQ-037 Scenario: rst=1 at cycle 6 of a run -> busy=0 and step_en=0 from cycle 7; no done pulse; product=0.
REQ-038 Scenario: BOOTH_CTRL_TIMEOUT_EN defined, step_rdy held at 0 -> err=1 after 8 WAIT cycles, busy=0, no done; next start clears err.
REQ-039 Scenario: step_rdy pulsed while in ISSUE or IDLE -> acc unchanged; final product still correct.
